// File: rtl/video_trig_pkg.sv
// rtl/video_trig_pkg.sv - shared types and constants for the video line trigger
package video_trig_pkg;

    // Per-channel trigger state
    typedef enum logic [1:0] {
        CH_IDLE  = 2'b00,
        CH_ARMED = 2'b01,
        CH_FIRED = 2'b10
    } ch_state_t;

    // Field qualifier codes (00 and 11 both mean "any field")
    localparam logic [1:0] FQ_ANY      = 2'b00;
    localparam logic [1:0] FQ_ODD      = 2'b01;
    localparam logic [1:0] FQ_EVEN     = 2'b10;
    localparam logic [1:0] FQ_ANY_ALT  = 2'b11;

    // Default line numbering for the two supported standards
    localparam int NTSC_TOTAL_DEF = 525;
    localparam int PAL_TOTAL_DEF  = 625;
    localparam int NTSC_START_DEF = 5;
    localparam int PAL_START_DEF  = 2;

    // True when a channel's field qualifier accepts the current field
    function automatic logic field_match(input logic [1:0] qual, input logic odd);
        logic ok;
        case (qual)
            FQ_ODD:     ok = odd;
            FQ_EVEN:    ok = ~odd;
            FQ_ANY,
            FQ_ANY_ALT: ok = 1'b1;
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/video_line_trigger_if.sv
// rtl/video_line_trigger_if.sv - sync inputs, channel configuration and trigger outputs
//   slave  : seen by video_line_trigger (sync/config in, triggers/status out)
//   master : seen by the driver of sync strobes and configuration
interface video_line_trigger_if #(
    parameter int NUM_CH = 4,
    parameter int LINE_W = 10
);
    logic                       hs_in;
    logic                       odd_field_tri;
    logic                       even_field_tri;
    logic                       video_mode;
    logic                       arm;
    logic                       auto_rearm;
    logic [NUM_CH-1:0]          ch_en;
    logic [NUM_CH*LINE_W-1:0]   ch_line;
    logic [2*NUM_CH-1:0]        ch_field;
    logic [NUM_CH-1:0]          tri_out;
    logic [NUM_CH-1:0]          tri_pulse;
    logic [LINE_W-1:0]          line_count;
    logic                       odd_field;

    modport slave (
        input  hs_in, odd_field_tri, even_field_tri, video_mode, arm, auto_rearm,
               ch_en, ch_line, ch_field,
        output tri_out, tri_pulse, line_count, odd_field
    );

    modport master (
        output hs_in, odd_field_tri, even_field_tri, video_mode, arm, auto_rearm,
               ch_en, ch_line, ch_field,
        input  tri_out, tri_pulse, line_count, odd_field
    );
endinterface

// File: rtl/vlt_channel.sv
// rtl/vlt_channel.sv - one trigger channel: IDLE/ARMED/FIRED FSM, config buffers, line compare
//   clk, rst      : clock, synchronous active-high reset
//   hs_tick       : qualified line edge (running, no field strobe this cycle)
//   field_start   : field strobe this cycle
//   odd_field     : current field parity
//   count         : line number before this edge's increment
//   arm, auto_rearm, en, line_in, field_in : control and live configuration
//   tri_out       : trigger level, tri_pulse : one-cycle trigger pulse
module vlt_channel
    import video_trig_pkg::*;
#(
    parameter int LINE_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs_tick,
    input  logic              field_start,
    input  logic              odd_field,
    input  logic [LINE_W-1:0] count,
    input  logic              arm,
    input  logic              auto_rearm,
    input  logic              en,
    input  logic [LINE_W-1:0] line_in,
    input  logic [1:0]        field_in,
    output logic              tri_out,
    output logic              tri_pulse
);

    ch_state_t         state;
    logic [LINE_W-1:0] buf_line;
    logic [1:0]        buf_field;

    // Line 0 and lines beyond the frame total can never equal the counter,
    // so such channels simply stay armed.
    logic hit;
    assign hit = hs_tick && (count == buf_line) && field_match(buf_field, odd_field);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CH_IDLE;
            tri_out   <= 1'b0;
            tri_pulse <= 1'b0;
            buf_line  <= '0;
            buf_field <= FQ_ANY;
        end else begin
            tri_pulse <= 1'b0;
            if (!en) begin
                state   <= CH_IDLE;
                tri_out <= 1'b0;
            end else begin
                case (state)
                    CH_IDLE: begin
                        if (arm) begin
                            state     <= CH_ARMED;
                            buf_line  <= line_in;
                            buf_field <= field_in;
                        end
                    end
                    CH_ARMED: begin
                        // arm takes priority over a coincident match
                        if (arm) begin
                            buf_line  <= line_in;
                            buf_field <= field_in;
                        end else if (hit) begin
                            state     <= CH_FIRED;
                            tri_out   <= 1'b1;
                            tri_pulse <= 1'b1;
                        end
                    end
                    CH_FIRED: begin
                        if (arm || (field_start && auto_rearm)) begin
                            state     <= CH_ARMED;
                            tri_out   <= 1'b0;
                            buf_line  <= line_in;
                            buf_field <= field_in;
                        end
                    end
                    default: begin
                        state   <= CH_IDLE;
                        tri_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/video_line_trigger.sv
// rtl/video_line_trigger.sv - multi-channel video line trigger top
//   clk_in : system clock, rst_in : synchronous active-high reset
//   bus    : hs/field strobes, mode, arm and per-channel config in;
//            tri_out, tri_pulse, line_count, odd_field out
module video_line_trigger
    import video_trig_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int LINE_W     = 10,
    parameter int NTSC_TOTAL = NTSC_TOTAL_DEF,
    parameter int PAL_TOTAL  = PAL_TOTAL_DEF,
    parameter int NTSC_START = NTSC_START_DEF,
    parameter int PAL_START  = PAL_START_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    video_line_trigger_if.slave bus
);

    localparam logic [LINE_W-1:0] NTSC_TOTAL_L = LINE_W'(NTSC_TOTAL);
    localparam logic [LINE_W-1:0] PAL_TOTAL_L  = LINE_W'(PAL_TOTAL);
    localparam logic [LINE_W-1:0] NTSC_START_L = LINE_W'(NTSC_START);
    localparam logic [LINE_W-1:0] PAL_START_L  = LINE_W'(PAL_START);

    logic              hs_s0, hs_s1, hs_fall;
    logic              running, odd_r, mode_r;
    logic [LINE_W-1:0] count;
    logic [LINE_W-1:0] total;
    logic              field_start, hs_tick;
    logic [NUM_CH-1:0] tri_out_w, tri_pulse_w;

    // Mode is captured at the field strobe so a mid-field change never
    // alters the wrap point of the field in progress.
    assign total       = mode_r ? PAL_TOTAL_L : NTSC_TOTAL_L;
    assign field_start = bus.odd_field_tri | bus.even_field_tri;
    // A field strobe suppresses counting and comparing in the same cycle.
    assign hs_tick     = hs_fall & running & ~field_start;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hs_s0   <= 1'b1;
            hs_s1   <= 1'b1;
            hs_fall <= 1'b0;
            running <= 1'b0;
            odd_r   <= 1'b0;
            mode_r  <= 1'b0;
            count   <= '0;
        end else begin
            hs_s0   <= bus.hs_in;
            hs_s1   <= hs_s0;
            hs_fall <= hs_s1 & ~hs_s0;
            if (field_start) begin
                count   <= bus.video_mode ? PAL_START_L : NTSC_START_L;
                running <= 1'b1;
                odd_r   <= bus.odd_field_tri;   // odd wins when both strobe
                mode_r  <= bus.video_mode;
            end else if (hs_tick) begin
                count <= (count == total) ? LINE_W'(1) : count + LINE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        vlt_channel #(.LINE_W(LINE_W)) u_ch (
            .clk         (clk_in),
            .rst         (rst_in),
            .hs_tick     (hs_tick),
            .field_start (field_start),
            .odd_field   (odd_r),
            .count       (count),
            .arm         (bus.arm),
            .auto_rearm  (bus.auto_rearm),
            .en          (bus.ch_en[i]),
            .line_in     (bus.ch_line[i*LINE_W +: LINE_W]),
            .field_in    (bus.ch_field[2*i +: 2]),
            .tri_out     (tri_out_w[i]),
            .tri_pulse   (tri_pulse_w[i])
        );
    end

    assign bus.tri_out    = tri_out_w;
    assign bus.tri_pulse  = tri_pulse_w;
    assign bus.line_count = count;
    assign bus.odd_field  = odd_r;

endmodule

// File: tb/tb_video_line_trigger.sv
// tb/tb_video_line_trigger.sv - directed self-checking bench for video_line_trigger
module tb_video_line_trigger;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    video_line_trigger_if #(.NUM_CH(4), .LINE_W(10)) bus ();

    video_line_trigger #(.NUM_CH(4), .LINE_W(10)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One hs low pulse; on return the line edge has just been processed.
    task automatic hs_pulse();
        bus.hs_in = 1'b0;
        tick();
        bus.hs_in = 1'b1;
        tick();
        tick();
    endtask

    task automatic hs_pulses(input int n);
        for (int i = 0; i < n; i++) hs_pulse();
    endtask

    task automatic odd_strobe();
        bus.odd_field_tri = 1'b1;
        tick();
        bus.odd_field_tri = 1'b0;
    endtask

    task automatic even_strobe();
        bus.even_field_tri = 1'b1;
        tick();
        bus.even_field_tri = 1'b0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic set_ch(input int i, input int line, input logic [1:0] fq);
        bus.ch_line[i*10 +: 10] = 10'(line);
        bus.ch_field[2*i +: 2]  = fq;
    endtask

    initial begin
        bus.hs_in = 1'b1;
        bus.odd_field_tri = 1'b0;
        bus.even_field_tri = 1'b0;
        bus.video_mode = 1'b0;
        bus.arm = 1'b0;
        bus.auto_rearm = 1'b0;
        bus.ch_en = 4'b0000;
        bus.ch_line = '0;
        bus.ch_field = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_tri_out", 32'(bus.tri_out), 0);
        check("rst_tri_pulse", 32'(bus.tri_pulse), 0);
        check("rst_line_count", 32'(bus.line_count), 0);
        check("rst_odd_field", 32'(bus.odd_field), 0);
        hs_pulse();
        check("idle_no_count", 32'(bus.line_count), 0);

        // NTSC, ch0 line 20, any field
        bus.ch_en = 4'b0001;
        set_ch(0, 20, 2'b00);
        do_arm();
        odd_strobe();
        check("ntsc_start", 32'(bus.line_count), 5);
        check("odd_field_set", 32'(bus.odd_field), 1);
        hs_pulses(15);
        check("ntsc_cnt20", 32'(bus.line_count), 20);
        check("ntsc_not_yet", 32'(bus.tri_out), 0);
        hs_pulse();
        check("ntsc_fire_out", 32'(bus.tri_out), 4'b0001);
        check("ntsc_fire_pulse", 32'(bus.tri_pulse), 4'b0001);
        check("ntsc_cnt21", 32'(bus.line_count), 21);
        tick();
        check("pulse_one_cycle", 32'(bus.tri_pulse), 0);
        check("level_held", 32'(bus.tri_out), 4'b0001);
        hs_pulse();
        check("no_refire", 32'(bus.tri_pulse), 0);

        // PAL wrap, ch1 line 625
        bus.ch_en = 4'b0010;
        bus.video_mode = 1'b1;
        set_ch(1, 625, 2'b00);
        do_arm();
        check("ch0_disabled", 32'(bus.tri_out), 0);
        odd_strobe();
        check("pal_start", 32'(bus.line_count), 2);
        hs_pulses(622);
        check("pal_cnt624", 32'(bus.line_count), 624);
        hs_pulse();
        check("pal_cnt625", 32'(bus.line_count), 625);
        check("pal_not_yet", 32'(bus.tri_out), 0);
        hs_pulse();
        check("pal_wrap", 32'(bus.line_count), 1);
        check("pal_fire_out", 32'(bus.tri_out), 4'b0010);
        check("pal_fire_pulse", 32'(bus.tri_pulse), 4'b0010);

        // Field qualification with auto re-arm
        bus.video_mode = 1'b0;
        bus.ch_en = 4'b0011;
        set_ch(0, 10, 2'b01);
        set_ch(1, 10, 2'b10);
        bus.auto_rearm = 1'b1;
        do_arm();
        check("rearm_clears", 32'(bus.tri_out), 0);
        odd_strobe();
        hs_pulses(6);
        check("odd_fires_ch0", 32'(bus.tri_out), 4'b0001);
        check("odd_pulse_ch0", 32'(bus.tri_pulse), 4'b0001);
        even_strobe();
        check("even_rearm", 32'(bus.tri_out), 0);
        check("even_odd_flag", 32'(bus.odd_field), 0);
        check("even_start", 32'(bus.line_count), 5);
        hs_pulses(6);
        check("even_fires_ch1", 32'(bus.tri_out), 4'b0010);
        check("even_pulse_ch1", 32'(bus.tri_pulse), 4'b0010);

        // Strobe coincident with line edge; unreachable lines
        bus.auto_rearm = 1'b0;
        bus.ch_en = 4'b0111;
        set_ch(0, 0, 2'b00);
        set_ch(1, 700, 2'b00);
        set_ch(2, 5, 2'b00);
        do_arm();
        odd_strobe();
        bus.hs_in = 1'b0;
        tick();
        bus.hs_in = 1'b1;
        tick();
        bus.odd_field_tri = 1'b1;
        tick();
        bus.odd_field_tri = 1'b0;
        check("strobe_wins_cnt", 32'(bus.line_count), 5);
        check("strobe_wins_nofire", 32'(bus.tri_out), 0);
        check("strobe_wins_nopulse", 32'(bus.tri_pulse), 0);
        hs_pulse();
        check("ch2_fires", 32'(bus.tri_out), 4'b0100);
        hs_pulses(525);
        check("full_frame_cnt", 32'(bus.line_count), 6);
        check("line0_700_never", 32'(bus.tri_out), 4'b0100);

        // arm coincident with matching edge on an ARMED channel
        bus.ch_en = 4'b0001;
        set_ch(0, 12, 2'b00);
        do_arm();
        hs_pulses(6);
        check("pre_arm_cnt12", 32'(bus.line_count), 12);
        bus.hs_in = 1'b0;
        tick();
        bus.hs_in = 1'b1;
        tick();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check("arm_wins_pulse", 32'(bus.tri_pulse), 0);
        check("arm_wins_out", 32'(bus.tri_out), 0);
        check("arm_wins_cnt", 32'(bus.line_count), 13);
        set_ch(0, 14, 2'b00);
        do_arm();
        hs_pulses(2);
        check("fire_line14", 32'(bus.tri_out), 4'b0001);
        bus.ch_en = 4'b0000;
        tick();
        check("disable_clears", 32'(bus.tri_out), 0);

        // reset mid-field
        bus.ch_en = 4'b0011;
        set_ch(0, 16, 2'b00);
        set_ch(1, 16, 2'b00);
        do_arm();
        hs_pulses(2);
        check("pre_reset_out", 32'(bus.tri_out), 4'b0011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out", 32'(bus.tri_out), 0);
        check("mid_rst_pulse", 32'(bus.tri_pulse), 0);
        check("mid_rst_cnt", 32'(bus.line_count), 0);
        check("mid_rst_odd", 32'(bus.odd_field), 0);
        do_arm();
        hs_pulses(3);
        check("post_rst_idle_cnt", 32'(bus.line_count), 0);
        check("post_rst_no_fire", 32'(bus.tri_out), 0);
        odd_strobe();
        check("post_rst_start", 32'(bus.line_count), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_line_trigger.md
# video_line_trigger

Multi-channel, parametrised video line trigger for the DSO video-trigger path. It counts horizontal-sync falling edges from a field-start strobe and fires an independent trigger per channel when the line count reaches that channel's programmed line. Supports NTSC/PAL line numbering, per-channel field qualification, and manual or automatic re-arm. It sits between the sync separator (hs/field strobes) and the acquisition trigger mux.

## Interface
Parameters:
- NUM_CH, 4, number of independent trigger channels (1..8)
- LINE_W, 10, line-counter and line-select width
- NTSC_TOTAL, 525, NTSC lines per frame (wrap point)
- PAL_TOTAL, 625, PAL lines per frame (wrap point)
- NTSC_START, 5, counter load value on NTSC field start
- PAL_START, 2, counter load value on PAL field start

Ports:
- clk_in  in  1  system clock; all logic on rising edge
- rst_in  in  1  synchronous reset, active-high
- hs_in  in  1  horizontal sync, active-low pulse, asynchronous to clk_in
- odd_field_tri  in  1  one-cycle odd-field start strobe, synchronous to clk_in
- even_field_tri  in  1  one-cycle even-field start strobe, synchronous to clk_in
- video_mode  in  1  0 = NTSC, 1 = PAL
- arm  in  1  one-cycle strobe: arm all enabled channels
- auto_rearm  in  1  1 = field start re-arms fired channels
- ch_en  in  NUM_CH  per-channel enable
- ch_line  in  NUM_CH*LINE_W  target line, channel i at [i*LINE_W +: LINE_W]
- ch_field  in  2*NUM_CH  per-channel field qualifier: 00 any, 01 odd only, 10 even only, 11 any
- tri_out  out  NUM_CH  trigger level, held until re-arm
- tri_pulse  out  NUM_CH  one-cycle trigger pulse
- line_count  out  LINE_W  current line number
- odd_field  out  1  1 while current field started by odd_field_tri

## Operation
- hs_in passes a 2-flop synchroniser (hs_s0, hs_s1); hs_fall = hs_s1 & ~hs_s0.
- Line counter: idle (running=0) after reset. Field strobe loads NTSC_START/PAL_START per video_mode, sets running, sets odd_field (1 for odd strobe, 0 for even). On hs_fall with running: count == total → 1, else count+1.
- Per-channel FSM, states IDLE, ARMED, FIRED:
  - IDLE → ARMED on arm with ch_en[i]=1; ch_line/ch_field latched into channel buffer at this transition.
  - ARMED → FIRED on hs_fall when running, pre-increment count == buffered line, and field qualifier matches odd_field; tri_out[i]←1, tri_pulse[i]←1 for one cycle.
  - FIRED → ARMED on arm (ch_en=1), or on field strobe when auto_rearm=1 and ch_en=1; tri_out[i]←0, buffers relatched.
  - Any state → IDLE when ch_en[i]=0; tri_out[i]←0.
- Buffered line 0 or above current mode total: channel never fires, stays ARMED.
- Changing ch_line while ARMED has no effect until next re-arm.
- video_mode change takes effect at the next field strobe; counter is not reloaded mid-field.

## Timing
- Reset: tri_out=0, tri_pulse=0, line_count=0, odd_field=0, running=0, all channels IDLE, synchroniser flops=1.
- Latency: hs_in first sampled low at edge k → hs_fall true in cycle after edge k+1 → tri_out/tri_pulse high after edge k+2.
- tri_pulse exactly one cycle per firing; at most one firing per channel per arm.
- Simultaneous field strobe and hs_fall: strobe wins; counter loads, no compare that cycle.
- Simultaneous odd and even strobes: odd wins.
- Simultaneous arm and matching hs_fall on an IDLE channel: arm only (channel ARMED, no fire).
- Simultaneous arm and firing on an ARMED channel: arm wins (stays ARMED, tri_out=0).
- rst_in mid-field: immediate return to reset state; running=0 until next field strobe.

## Structure
- Shared package video_trig_pkg: channel state encoding (IDLE/ARMED/FIRED), field-qualifier codes, NTSC/PAL default constants.
- Sub-module vlt_channel: one channel FSM + buffers + comparator, instantiated NUM_CH times via generate; top holds synchroniser, edge detect, line counter.

## Test plan
- NTSC, ch0 line=20 any field, arm, odd strobe, 15 hs pulses → tri_out[0] rises after 16th hs fall (count 20), single tri_pulse, no further pulse.
- PAL, count from 2 through 625 → line_count wraps to 1 on 624th hs fall; ch1 line=625 fires on that hs fall.
- ch0 field=01, ch1 field=10, both line=10, auto_rearm=1: odd field fires only ch0; even field re-arms and fires only ch1.
- Field strobe in same cycle as hs_fall → line_count = start value, no firing; ch line=0 and ch line=700 (NTSC) never fire.
- arm coincident with matching hs_fall on ARMED channel → no tri_pulse, tri_out=0; ch_en dropped while FIRED → tri_out=0 next cycle.
- rst_in asserted mid-field with tri_out=4'b0011 → all outputs 0 next cycle; hs pulses ignored until field strobe.
